activity_scanner: RTL
=====================

Name: activity_scanner

Overview:
- Parametrised activity bitmap with a sequential drain of set-bit indices, for activity-driven neuron/synapse processing.
- Producers mark active indices one per cycle. On `start`, the block scans the bitmap from the highest index downward, 16 bits per chunk.
- Each set bit is emitted as an index on a valid/ready stream and cleared on handshake.
- Successor to the single-cycle 16-bit priority encode: arbitrary width, stateful, back-pressured.

Parameters:
- WIDTH, 256, number of tracked indices; must be a multiple of 16 and at least 16.
- IDX_W, $clog2(WIDTH), index width (derived; not overridden).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- mark_valid  in  1  set bitmap[mark_idx] this cycle.
- mark_idx  in  IDX_W  index to mark; values >= WIDTH are ignored.
- clear  in  1  synchronous clear of the whole bitmap; aborts any scan.
- start  in  1  begin a scan; honoured only in IDLE.
- busy  out  1  high in SCAN or EMIT.
- out_valid  out  1  out_idx holds a pending active index.
- out_ready  in  1  consumer accepts out_idx.
- out_idx  out  IDX_W  emitted index, highest first.
- done  out  1  one-cycle pulse when a scan completes normally.
- emit_count  out  IDX_W+1  indices emitted in the current or last scan.

Behaviour:
- Reset (async, reset_n=0): bitmap=0, state=IDLE, ptr=0, out_valid=0, out_idx=0, done=0, busy=0, emit_count=0.
- Chunk c = bitmap[16c+15:16c]; NCHUNK = WIDTH/16; ptr is IDX_W-4 bits wide.
- IDLE:
  - start & !clear -> SCAN, ptr=NCHUNK-1, emit_count=0.
  - start while not IDLE is ignored.
- SCAN (one chunk per cycle):
  - Chunk[ptr] nonzero: out_idx <= {ptr, highest set bit of chunk}, out_valid<=1, state->EMIT.
  - Chunk zero and ptr>0: ptr<=ptr-1.
  - Chunk zero and ptr==0: done<=1 for one cycle, state->IDLE.
  - Latency from start to first out_valid is 1 + (empty chunks above the first set chunk) + 1 cycles.
- EMIT:
  - out_valid and out_idx are held stable until out_ready.
  - On handshake: bitmap[out_idx]<=0, emit_count++, out_valid<=0, state->SCAN with ptr unchanged, so the same chunk is re-examined.
  - Throughput is one index per 2 cycles within a chunk.
- Marks accepted in every state, including during a scan:
  - Mark into chunk > ptr: retained for the next scan, not emitted now.
  - Mark into chunk <= ptr: emitted in this scan, in descending order.
  - Mark of the bit being cleared by the same-cycle handshake: mark wins and the bit stays set. A new spike must never be lost; it re-emits on the SCAN revisit.
- clear:
  - Highest priority: bitmap<=0 regardless of a same-cycle mark.
  - If busy: state->IDLE, out_valid<=0, no done pulse; emit_count holds its value.
- clear & start in the same cycle: clear wins, and no scan starts.
- done and out_valid are never high together.
- busy is registered, derived from the state register.
- Empty bitmap on start: NCHUNK+1 cycles later done pulses with emit_count=0.

Decomposition:
- Package ucaspian_scan_pkg:
  - CHUNK_W=16 and CHUNK_IDX_W=4.
  - State enum scan_state_t {IDLE, SCAN, EMIT}.
- Sub-module: find_set_bit_16, instantiated once on the ptr-selected chunk to produce the within-chunk index.
- Chunk select is a plain mux in this block; it is not duplicated per chunk.

Test Plan:
- Reset mid-EMIT (WIDTH=256, bit 200 pending): assert reset_n=0 -> out_valid=0, busy=0, bitmap cleared immediately; a following start yields done with emit_count=0.
- Mark 3, 17, 255, then start, out_ready=1 -> out_idx sequence 255, 17, 3; done pulses; emit_count=3; bitmap empty afterwards.
- Mark 0..15 all, start, out_ready toggling 1 cycle on / 2 off -> 15 down to 0 in order; out_idx stable while out_valid & !out_ready; emit_count=16.
- During a scan at ptr=2, mark 250 (chunk 15) and 5 (chunk 0) -> 5 emitted this scan, 250 not emitted; a second scan emits only 250.
- Handshake on idx 40 while mark_idx=40 in the same cycle -> 40 emitted again before the scan leaves chunk 2; emit_count counts both.
- clear asserted in EMIT, with a same-cycle mark_idx=9 -> state IDLE, no done, out_valid=0; next scan emits nothing, done after 17 cycles (WIDTH=256).

Source files
------------

// File: rtl/ucaspian_scan_pkg.sv
// Shared types and constants for the activity scanner and its chunk encoder.
package ucaspian_scan_pkg;

    localparam int CHUNK_W     = 16;
    localparam int CHUNK_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } scan_state_t;

endpackage

// File: rtl/find_set_bit_16.sv
// Highest-set-bit encoder for one 16-bit chunk of the activity bitmap.
module find_set_bit_16
    import ucaspian_scan_pkg::*;
(
    input  logic [CHUNK_W-1:0]     bits,
    output logic                   found,
    output logic [CHUNK_IDX_W-1:0] idx
);

    // Ascending scan so the last (highest) set bit wins.
    always_comb begin
        found = |bits;
        idx   = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            if (bits[i]) begin
                idx = CHUNK_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/activity_scanner.sv
// Activity bitmap with a back-pressured, highest-first drain of set indices.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  IDLE  | no scan running; bitmap only collects marks
//  SCAN  | examine chunk[ptr]; load its top set bit or step down one chunk
//  EMIT  | out_idx presented; waiting for out_ready, then revisit chunk[ptr]
module activity_scanner
    import ucaspian_scan_pkg::*;
#(
    parameter  int WIDTH = 256,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mark_valid,
    input  logic [IDX_W-1:0] mark_idx,
    input  logic             clear,
    input  logic             start,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             done,
    output logic [IDX_W:0]   emit_count
);

    localparam int NCHUNK = WIDTH / CHUNK_W;
    // A single-chunk instance still needs a one-bit pointer that stays at zero.
    localparam int PTR_W  = (IDX_W > CHUNK_IDX_W) ? (IDX_W - CHUNK_IDX_W) : 1;
    localparam logic [PTR_W-1:0] PTR_TOP   = PTR_W'(NCHUNK - 1);
    localparam logic [IDX_W:0]   WIDTH_LIM = (IDX_W + 1)'(WIDTH);

    scan_state_t                   state;
    logic [PTR_W-1:0]              ptr;
    logic [WIDTH-1:0]              bitmap;
    logic [WIDTH-1:0]              bitmap_nxt;
    logic [CHUNK_W-1:0]            chunk;
    logic                          chunk_found;
    logic [CHUNK_IDX_W-1:0]        chunk_bit;
    logic [PTR_W+CHUNK_IDX_W-1:0]  idx_full;
    logic                          handshake;
    logic                          mark_hit;

    assign handshake = (state == EMIT) && out_valid && out_ready;
    assign mark_hit  = mark_valid && ({1'b0, mark_idx} < WIDTH_LIM);
    assign idx_full  = {ptr, chunk_bit};

    // Pointer-driven mux selecting the chunk under examination.
    always_comb begin
        chunk = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            if (ptr == PTR_W'(c)) begin
                chunk = bitmap[c*CHUNK_W +: CHUNK_W];
            end
        end
    end

    find_set_bit_16 u_find (
        .bits  (chunk),
        .found (chunk_found),
        .idx   (chunk_bit)
    );

    // Bitmap update: the handshake clears, a same-cycle mark re-sets (a spike
    // is never lost), and clear overrides everything.
    always_comb begin
        bitmap_nxt = bitmap;
        if (handshake) begin
            bitmap_nxt[out_idx] = 1'b0;
        end
        if (mark_hit) begin
            bitmap_nxt[mark_idx] = 1'b1;
        end
        if (clear) begin
            bitmap_nxt = '0;
        end
    end

    // Bitmap register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bitmap <= '0;
        end else begin
            bitmap <= bitmap_nxt;
        end
    end

    // Scan controller with registered stream, status and count outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            out_valid  <= 1'b0;
            out_idx    <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            emit_count <= '0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                // Abort: drop any pending index, no done pulse, count holds.
                state     <= IDLE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state      <= SCAN;
                            busy       <= 1'b1;
                            ptr        <= PTR_TOP;
                            emit_count <= '0;
                        end
                    end
                    SCAN: begin
                        if (chunk_found) begin
                            out_idx   <= idx_full[IDX_W-1:0];
                            out_valid <= 1'b1;
                            state     <= EMIT;
                        end else if (ptr != '0) begin
                            ptr <= ptr - PTR_W'(1);
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    EMIT: begin
                        // ptr is left alone so the same chunk is re-examined.
                        if (out_ready) begin
                            out_valid  <= 1'b0;
                            emit_count <= emit_count + (IDX_W + 1)'(1);
                            state      <= SCAN;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
